// File: rtl/session_pkg.sv
// Shared session-layer encodings: command codes, responder state codes and user key codes.
// Used by the caller-side FSM, the transport framing and the callee-side responder.
package session_pkg;

   localparam logic [3:0] CMD_IDLE     = 4'd0;
   localparam logic [3:0] CMD_CALL_REQ = 4'd1;
   localparam logic [3:0] CMD_ACCEPT   = 4'd2;
   localparam logic [3:0] CMD_REJECT   = 4'd3;
   localparam logic [3:0] CMD_BUSY     = 4'd4;
   localparam logic [3:0] CMD_HANGUP   = 4'd5;
   localparam logic [3:0] CMD_ACK      = 4'd6;

   localparam logic [3:0] KEY_NONE     = 4'd0;
   localparam logic [3:0] KEY_ANSWER   = 4'd2;
   localparam logic [3:0] KEY_DECLINE  = 4'd3;
   localparam logic [3:0] KEY_HANGUP   = 4'd5;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_RINGING   = 4'd1,
      S_SEND_ACC  = 4'd2,
      S_CONNECTED = 4'd3,
      S_SEND_REJ  = 4'd4,
      S_SEND_HUP  = 4'd5
   } resp_state_e;

endpackage

// File: rtl/session_responder_if.sv
// Transport-side bus of the session responder: received command strobe and tx response handshake.
interface session_responder_if;

   logic       net_valid;
   logic [3:0] net_cmd;
   logic       tx_valid;
   logic [3:0] tx_cmd;
   logic       tx_ready;

   modport master (
      output net_valid, net_cmd, tx_ready,
      input  tx_valid, tx_cmd
   );

   modport slave (
      input  net_valid, net_cmd, tx_ready,
      output tx_valid, tx_cmd
   );

endinterface

// File: rtl/session_tx_slot.sv
// Single-entry valid/ready response register. An FSM load overrides a BUSY load in the same cycle;
// BUSY only enters an empty slot.
module session_tx_slot
   import session_pkg::*;
(
   input  logic       clk,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_cmd,
   input  logic       busy_load,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [3:0] tx_cmd
);

   always_ff @(posedge clk) begin
      if (clear) begin
         tx_valid <= 1'b0;
         tx_cmd   <= CMD_IDLE;
      end else if (load) begin
         tx_valid <= 1'b1;
         tx_cmd   <= load_cmd;
      end else if (busy_load && !tx_valid) begin
         tx_valid <= 1'b1;
         tx_cmd   <= CMD_BUSY;
      end else if (tx_valid && tx_ready) begin
         tx_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/session_responder.sv
// Callee-side session FSM: ringing, answer, decline, busy and hang-up sequencing toward the transport.
//
//   state       | meaning
//   S_IDLE      | no call; waiting for CALL_REQ
//   S_RINGING   | ringer on; waiting for key, caller cancel or ring timeout
//   S_SEND_ACC  | sending ACCEPT; CONNECTED after handshake (IDLE if caller hung up meanwhile)
//   S_CONNECTED | audio path enabled
//   S_SEND_REJ  | sending REJECT (decline or no answer); IDLE after handshake
//   S_SEND_HUP  | sending HANGUP after local hang-up; IDLE after handshake
module session_responder
   import session_pkg::*;
#(
   parameter int RING_TIMEOUT = 1000,
   parameter int CNT_W        = 16
) (
   input  logic                clk,
   input  logic                reset,
   session_responder_if.slave  bus,
   input  logic [3:0]          userInp,
   output logic                ringing,
   output logic                connected,
   output logic [3:0]          current_state
);

   localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   resp_state_e      state_q, state_d;
   logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
   logic             hup_seen_q, hup_seen_d;

   logic       net_call, net_hup;
   logic       in_send, tx_fire, rsp_done, rsp_load, busy_load;
   logic [3:0] rsp_cmd;

   assign net_call = bus.net_valid && (bus.net_cmd == CMD_CALL_REQ);
   assign net_hup  = bus.net_valid && (bus.net_cmd == CMD_HANGUP);

   always_comb begin
      rsp_cmd = CMD_IDLE;
      in_send = 1'b1;
      case (state_q)
         S_SEND_ACC: rsp_cmd = CMD_ACCEPT;
         S_SEND_REJ: rsp_cmd = CMD_REJECT;
         S_SEND_HUP: rsp_cmd = CMD_HANGUP;
         default:    in_send = 1'b0;
      endcase
   end

   // A BUSY may be occupying the slot when a send state is entered; the state's own response
   // loads once the slot frees (or on the edge the BUSY completes) and only its handshake advances.
   assign tx_fire   = bus.tx_valid && bus.tx_ready;
   assign rsp_done  = in_send && tx_fire && (bus.tx_cmd == rsp_cmd);
   assign rsp_load  = in_send && (!bus.tx_valid || (tx_fire && !rsp_done));
   assign busy_load = net_call && (state_q != S_IDLE);

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      hup_seen_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (net_call) begin
               state_d    = S_RINGING;
               ring_cnt_d = '0;
            end
         end
         S_RINGING: begin
            if (ring_cnt_q != CNT_MAX) ring_cnt_d = ring_cnt_q + 1'b1;
            if (net_hup)                      state_d = S_IDLE;
            else if (userInp == KEY_ANSWER)   state_d = S_SEND_ACC;
            else if (userInp == KEY_DECLINE)  state_d = S_SEND_REJ;
            else if (ring_cnt_q == RING_LAST) state_d = S_SEND_REJ;
         end
         S_SEND_ACC: begin
            hup_seen_d = hup_seen_q || net_hup;
            if (rsp_done) begin
               hup_seen_d = 1'b0;
               state_d    = (hup_seen_q || net_hup) ? S_IDLE : S_CONNECTED;
            end
         end
         S_CONNECTED: begin
            if (net_hup)                     state_d = S_IDLE;
            else if (userInp == KEY_HANGUP)  state_d = S_SEND_HUP;
         end
         S_SEND_REJ, S_SEND_HUP: begin
            if (rsp_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ring_cnt_q <= '0;
         hup_seen_q <= 1'b0;
         ringing    <= 1'b0;
         connected  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         hup_seen_q <= hup_seen_d;
         ringing    <= (state_d == S_RINGING);
         connected  <= (state_d == S_CONNECTED);
      end
   end

   assign current_state = state_q;

   session_tx_slot u_tx_slot (
      .clk       (clk),
      .clear     (reset),
      .load      (rsp_load),
      .load_cmd  (rsp_cmd),
      .busy_load (busy_load),
      .tx_ready  (bus.tx_ready),
      .tx_valid  (bus.tx_valid),
      .tx_cmd    (bus.tx_cmd)
   );

endmodule

// File: doc/session_responder.md
# session_responder

Callee-side session state machine for the telephony session layer; the answering end of the call-setup protocol driven by the caller-side session FSM. It consumes 4-bit session commands from the transport receive path and local user key commands, sequences ringing, answer, decline, busy and hang-up, and emits response commands to the transport transmit path over a valid/ready handshake. It sits between the transport layer and the user-interface/audio enable logic.

## Interface
- RING_TIMEOUT, 1000: number of cycles spent in RINGING without an answer before a no-answer REJECT is sent; must be ≥ 2.
- CNT_W, 16: width of the ring counter; RING_TIMEOUT < 2^CNT_W.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- net_valid  in  1  single-cycle strobe; net_cmd is valid.
- net_cmd  in  4  received session command (package encoding).
- userInp  in  4  level user key command; 0 = none, 2 = answer, 3 = decline, 5 = hang up.
- tx_valid  out  1  a response command is pending.
- tx_cmd  out  4  response command; stable while tx_valid is high.
- tx_ready  in  1  the transport accepts tx_cmd when tx_valid && tx_ready.
- ringing  out  1  high in RINGING (ringer drive).
- connected  out  1  high in CONNECTED (audio path enable).
- current_state  out  4  state code, for debug and the testbench.

## Operation
- Commands: IDLE=0, CALL_REQ=1, ACCEPT=2, REJECT=3, BUSY=4, HANGUP=5, ACK=6.
- States and codes: S_IDLE=0, S_RINGING=1, S_SEND_ACC=2, S_CONNECTED=3, S_SEND_REJ=4, S_SEND_HUP=5.
- S_IDLE: CALL_REQ goes to S_RINGING and clears the counter. All other net commands and all user input are ignored.
- S_RINGING:
  - net HANGUP (caller cancel) goes to S_IDLE.
  - user 2 goes to S_SEND_ACC.
  - user 3 goes to S_SEND_REJ.
  - When the counter reaches RING_TIMEOUT−1, go to S_SEND_REJ.
- S_SEND_ACC: load ACCEPT into the tx slot. On the handshake, go to S_CONNECTED.
- S_SEND_REJ: load REJECT into the tx slot. On the handshake, go to S_IDLE.
- S_CONNECTED:
  - net HANGUP goes to S_IDLE with no response sent.
  - user 5 goes to S_SEND_HUP.
- S_SEND_HUP: load HANGUP into the tx slot. On the handshake, go to S_IDLE.
- CALL_REQ while in any state other than S_IDLE: load BUSY into the tx slot only if the slot is empty; otherwise drop it. The state is unchanged.
- Unknown command codes (7–15) and ACK are ignored in every state.
- Net HANGUP received in S_SEND_ACC or S_SEND_HUP: complete the pending handshake, then go to S_IDLE.
- User inputs are level-sensitive. Once an action has moved the FSM out of the state that accepts it, a held key has no further effect.

## Timing
- Reset values: state S_IDLE, tx_valid=0, tx_cmd=0, ringing=0, connected=0, current_state=0, counter 0.
- Reset asserted mid-operation aborts on the next edge. Any pending tx is discarded without a handshake.
- All outputs are registered.
- A net or user event sampled at edge N changes the state at edge N, visible in cycle N+1.
- Response latency:
  - tx_valid rises at edge N+1, i.e. one cycle after the state that loads the slot is entered.
  - BUSY responses rise at edge N, the same edge as the CALL_REQ.
- tx_valid and tx_cmd hold until the cycle with tx_ready=1. tx_valid drops at the following edge.
- Back-to-back: a new response may load on the same edge the previous one completes.
- Simultaneous events in one cycle: net HANGUP wins over user input; user input wins over the ring timeout.
- Ring counter: CNT_W bits, increments only in S_RINGING, saturates and never wraps. The timeout transition happens RING_TIMEOUT cycles after entering S_RINGING.

## Structure
- Shared package `session_pkg`: command codes, state codes, and the user-key codes 2/3/5. The caller-side FSM and the transport framing use the same package.
- One natural sub-module, `session_tx_slot`: single-entry valid/ready output register with load, busy-if-empty load, and clear.
- The FSM, counter and output decode stay in the top module.

## Test plan
- Answer path: CALL_REQ → ringing=1 next cycle; userInp=2 → tx ACCEPT. Hold tx_ready=0 for 5 cycles and check tx_cmd=2 stays stable; then tx_ready=1 → connected=1, current_state=3.
- Hang-up path: from connected, userInp=5 → tx HANGUP (5) → S_IDLE. Separately, from connected, net HANGUP → idle with no tx_valid.
- No answer: RING_TIMEOUT=8, CALL_REQ, no user input → tx REJECT (3) appears exactly 9 cycles after CALL_REQ → idle after handshake.
- Busy: in connected, inject CALL_REQ → tx BUSY (4) while state stays 3. A second CALL_REQ while BUSY is still pending is dropped, so exactly one BUSY handshake is seen.
- Simultaneous events in RINGING: net HANGUP and userInp=2 in the same cycle → idle, no ACCEPT sent.
- Reset mid-operation: assert reset while tx_valid=1 in S_SEND_ACC → next cycle all outputs are 0 and current_state=0.
